// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared types and button bit positions for the NES pad reader.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        DONE   = 3'd4
    } nes_state_t;

    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_SEL  = 2;
    localparam int BTN_STRT = 3;
    localparam int BTN_UP   = 4;
    localparam int BTN_DN   = 5;
    localparam int BTN_L    = 6;
    localparam int BTN_R    = 7;

    typedef logic [7:0] nes_buttons_t;

endpackage

// File: rtl/nes_sync2.sv
// rtl/nes_sync2.sv - two-flop synchronizer; resets to 1, the idle level of the pad data line.
module nes_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - polls a serial NES pad and presents an active-high button word.
// Optional NES_PRESS_EDGE_EN adds a per-button press pulse output coincident with valid.
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 150,
    parameter int POLL_CYC  = 833333
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sdata,
    output logic         srl,
    output logic         sclk,
    output nes_buttons_t buttons,
`ifdef NES_PRESS_EDGE_EN
    output nes_buttons_t pressed,
`endif
    output logic         valid
);

    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int POLL_W = $clog2(POLL_CYC);

    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);

    nes_state_t        state;
    logic [PH_W-1:0]   phase_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [2:0]        bit_idx;
    nes_buttons_t      shift_reg;
    logic              sdata_sync;
    nes_buttons_t      final_word;

    nes_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sdata),
        .q     (sdata_sync)
    );

    // Bit 7 arrives on the last CLK_LO cycle, so the full word is assembled here.
    assign final_word = {sdata_sync, shift_reg[6:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            poll_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            srl       <= 1'b0;
            sclk      <= 1'b0;
            buttons   <= '0;
            valid     <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            pressed   <= '0;
`endif
        end else begin
            valid   <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            pressed <= '0;
`endif
            case (state)
                IDLE: begin
                    if (en) begin
                        if (poll_cnt == POLL_LAST) begin
                            poll_cnt  <= '0;
                            phase_cnt <= '0;
                            srl       <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        shift_reg[0] <= sdata_sync;
                        bit_idx      <= 3'd1;
                        phase_cnt    <= '0;
                        srl          <= 1'b0;
                        sclk         <= 1'b1;
                        state        <= CLK_HI;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CLK_HI: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        sclk      <= 1'b0;
                        state     <= CLK_LO;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CLK_LO: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt          <= '0;
                        shift_reg[bit_idx] <= sdata_sync;
                        if (bit_idx == 3'd7) begin
                            // Outputs are registered on entry so valid is high exactly during DONE.
                            buttons <= ~final_word;
                            valid   <= 1'b1;
`ifdef NES_PRESS_EDGE_EN
                            pressed <= ~final_word & ~buttons;
`endif
                            state   <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            sclk    <= 1'b1;
                            state   <= CLK_HI;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
